serial_eq_checker_amisha: RTL and testbench
===========================================

SERIAL_EQ_CHECKER_AMISHA -- requirements
Module: serial_eq_checker_amisha

Interface
REQ-001 Parameter N_BITS, default 8, SHALL set the number of bit comparisons per frame (legal range 2..255).
REQ-002 Derived width CW = clog2(N_BITS+1) SHALL size err_count_amisha; IW = clog2(N_BITS) SHALL size first_err_idx_amisha.
REQ-003 clk_amisha  input  1  single clock; all state updates on rising edge.
REQ-004 reset_amisha  input  1  reset, asynchronous, active-high.
REQ-005 start_amisha  input  1  begins a new frame when sampled high in IDLE.
REQ-006 eq_amisha  input  1  per-bit equality result from the upstream 1-bit comparator (1 = bits equal).
REQ-007 bit_valid_amisha  input  1  eq_amisha is meaningful this cycle.
REQ-008 busy_amisha  output  1  high while in RUN.
REQ-009 done_amisha  output  1  one-cycle pulse at frame completion.
REQ-010 match_amisha  output  1  1 = all N_BITS comparisons of last frame were equal.
REQ-011 err_count_amisha  output  CW  number of unequal bits in last/current frame.
REQ-012 first_err_idx_amisha  output  IW  index (0-based, arrival order) of first unequal bit.

Function
REQ-013 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN when start_amisha=1; same edge clears bit index, err_count_amisha, first_err_idx_amisha, match_amisha, and internal error-seen flag.
REQ-015 In RUN, each cycle with bit_valid_amisha=1 SHALL consume one comparison; cycles with bit_valid_amisha=0 SHALL change nothing (gaps allowed, no timeout).
REQ-016 On a consumed bit with eq_amisha=0: err_count_amisha increments by 1; if error-seen flag is 0, first_err_idx_amisha loads the current bit index and flag sets.
REQ-017 err_count_amisha SHALL never exceed N_BITS; no wrap.
REQ-018 RUN -> DONE on the edge consuming bit index N_BITS-1; bit index SHALL NOT wrap within a frame.
REQ-019 DONE lasts exactly one cycle: done_amisha=1, match_amisha=1 iff final err_count_amisha=0; then DONE -> IDLE unconditionally.
REQ-020 Latency: done_amisha rises the cycle after the edge sampling the last valid bit.
REQ-021 match_amisha, err_count_amisha, first_err_idx_amisha SHALL hold their values from DONE until the next accepted start.
REQ-022 first_err_idx_amisha SHALL read 0 when no mismatch occurred; match_amisha disambiguates.
REQ-023 start_amisha SHALL be ignored in RUN and DONE; bit_valid_amisha SHALL be ignored in IDLE and DONE.
REQ-024 start_amisha and bit_valid_amisha both high in IDLE: start accepted, bit NOT consumed.
REQ-025 busy_amisha=1 exactly when state is RUN; all outputs SHALL be registered (no combinational input-to-output path).

Reset
REQ-026 reset_amisha=1 SHALL immediately (without clock) force IDLE and drive busy_amisha=0, done_amisha=0, match_amisha=0, err_count_amisha=0, first_err_idx_amisha=0.
REQ-027 Reset asserted mid-RUN SHALL abandon the frame; no done_amisha pulse SHALL follow deassertion.
REQ-028 After reset deassertion the block SHALL wait in IDLE for start_amisha.

Verification (N_BITS=8)
REQ-029 All-equal: start, 8 consecutive valid bits eq=1 -> done pulse 1 cycle after 8th bit, match=1, err_count=0, first_err_idx=0.
REQ-030 Mismatches at indices 2 and 5 -> match=0, err_count=2, first_err_idx=2; values held 10 idle cycles.
REQ-031 All 8 bits eq=0 -> err_count=8, first_err_idx=0, match=0; no overflow.
REQ-032 Valid gaps: 8 valid bits spread over 20 cycles with bit_valid low between -> done only after 8th valid bit, busy high throughout.
REQ-033 start during RUN and bit_valid in IDLE -> no effect; start+bit_valid same cycle in IDLE -> frame needs 8 further valid bits.
REQ-034 Reset asserted after 4 bits (async, between edges) -> outputs zero immediately, no done pulse; subsequent full frame completes normally.

Source files
------------

// File: rtl/serial_eq_checker_amisha_if.sv
// Bundles the serial equality checker's control and result signals.
// The master drives the comparison stream; the slave is the checker itself.
interface serial_eq_checker_amisha_if #(
  parameter int N_BITS = 8
);
  localparam int CW = $clog2(N_BITS + 1);
  localparam int IW = $clog2(N_BITS);

  logic          start_amisha;
  logic          eq_amisha;
  logic          bit_valid_amisha;
  logic          busy_amisha;
  logic          done_amisha;
  logic          match_amisha;
  logic [CW-1:0] err_count_amisha;
  logic [IW-1:0] first_err_idx_amisha;

  modport master (
    output start_amisha,
    output eq_amisha,
    output bit_valid_amisha,
    input  busy_amisha,
    input  done_amisha,
    input  match_amisha,
    input  err_count_amisha,
    input  first_err_idx_amisha
  );

  modport slave (
    input  start_amisha,
    input  eq_amisha,
    input  bit_valid_amisha,
    output busy_amisha,
    output done_amisha,
    output match_amisha,
    output err_count_amisha,
    output first_err_idx_amisha
  );
endinterface

// File: rtl/serial_eq_checker_amisha.sv
// Accumulates N_BITS per-bit equality results into a frame verdict: error
// count, index of the first mismatch, and an all-equal flag.
module serial_eq_checker_amisha #(
  parameter int N_BITS = 8
) (
  input  logic                          clk_amisha,
  input  logic                          reset_amisha,
  serial_eq_checker_amisha_if.slave     bus
);
  localparam int CW = $clog2(N_BITS + 1);
  localparam int IW = $clog2(N_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] err_q, err_d;
  logic [IW-1:0] first_q, first_d;
  logic          seen_q, seen_d;
  logic          match_q, match_d;
  logic          busy_q;
  logic          done_q;

  // Next-state and datapath update for the frame FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    first_d = first_q;
    seen_d  = seen_q;
    match_d = match_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_amisha) begin
          state_d = ST_RUN;
          idx_d   = '0;
          err_d   = '0;
          first_d = '0;
          seen_d  = 1'b0;
          match_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.bit_valid_amisha) begin
          if (!bus.eq_amisha) begin
            // Saturating guard: the count can never pass N_BITS.
            if (err_q < CW'(N_BITS)) begin
              err_d = err_q + CW'(1);
            end else begin
              err_d = err_q;
            end
            if (!seen_q) begin
              first_d = idx_q;
              seen_d  = 1'b1;
            end else begin
              first_d = first_q;
            end
          end else begin
            err_d = err_q;
          end
          if (idx_q == IW'(N_BITS - 1)) begin
            state_d = ST_DONE;
            match_d = (err_d == '0);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; busy/done are registered from the next state.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      match_q <= match_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.busy_amisha          = busy_q;
  assign bus.done_amisha          = done_q;
  assign bus.match_amisha         = match_q;
  assign bus.err_count_amisha     = err_q;
  assign bus.first_err_idx_amisha = first_q;
endmodule

// File: tb/tb_serial_eq_checker_amisha.sv
// Directed bench for serial_eq_checker_amisha with N_BITS=8; expected values
// are hand-computed per scenario.
module tb_serial_eq_checker_amisha;
  logic clk_amisha;
  logic reset_amisha;
  int   checks_q;
  int   errors_q;

  serial_eq_checker_amisha_if #(.N_BITS(8)) bus ();

  serial_eq_checker_amisha #(.N_BITS(8)) dut (
    .clk_amisha   (clk_amisha),
    .reset_amisha (reset_amisha),
    .bus          (bus.slave)
  );

  initial clk_amisha = 1'b0;
  always #5 clk_amisha = ~clk_amisha;

  task automatic check_val(input string tag, input int act, input int exp);
    checks_q++;
    if (act !== exp) begin
      errors_q++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge pass, then settle 1 time unit.
  task automatic step(input logic s, input logic v, input logic e);
    bus.start_amisha     = s;
    bus.bit_valid_amisha = v;
    bus.eq_amisha        = e;
    @(posedge clk_amisha);
    #1;
  endtask

  task automatic check_result(input string tag, input int m, input int ec, input int fi);
    check_val({tag, "_match"}, int'(bus.match_amisha), m);
    check_val({tag, "_errcnt"}, int'(bus.err_count_amisha), ec);
    check_val({tag, "_first"}, int'(bus.first_err_idx_amisha), fi);
  endtask

  // Start a frame, feed 8 back-to-back bits, verify done timing and verdict.
  task automatic run_frame(input string tag, input logic [7:0] eqv,
                           input int m, input int ec, input int fi);
    step(1'b1, 1'b0, 1'b0);
    check_val({tag, "_busy_start"}, int'(bus.busy_amisha), 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, eqv[i]);
      if (i < 7) begin
        check_val({tag, "_done_early"}, int'(bus.done_amisha), 0);
      end else begin
        check_val({tag, "_done"}, int'(bus.done_amisha), 1);
        check_val({tag, "_busy_done"}, int'(bus.busy_amisha), 0);
      end
    end
    check_result(tag, m, ec, fi);
    step(1'b0, 1'b0, 1'b0);
    check_val({tag, "_done_pulse"}, int'(bus.done_amisha), 0);
  endtask

  initial begin
    int nvalid;
    checks_q             = 0;
    errors_q             = 0;
    reset_amisha         = 1'b1;
    bus.start_amisha     = 1'b0;
    bus.bit_valid_amisha = 1'b0;
    bus.eq_amisha        = 1'b0;
    #1;
    check_val("rst_busy", int'(bus.busy_amisha), 0);
    check_val("rst_done", int'(bus.done_amisha), 0);
    check_result("rst", 0, 0, 0);
    @(posedge clk_amisha);
    @(posedge clk_amisha);
    #1;
    reset_amisha = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check_val("idle_busy", int'(bus.busy_amisha), 0);

    // All equal.
    run_frame("alleq", 8'hFF, 1, 0, 0);

    // Mismatches at indices 2 and 5, then held for 10 idle cycles.
    run_frame("mm25", 8'b1101_1011, 0, 2, 2);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
    check_result("mm25_hold", 0, 2, 2);

    // All unequal: count reaches 8 without wrapping.
    run_frame("allne", 8'h00, 0, 8, 0);

    // Valid bits at cycles 2,4,7,9,12,14,17,19; only bit index 6 unequal.
    step(1'b1, 1'b0, 1'b0);
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      if ((i % 5 == 2) || (i % 5 == 4)) begin
        step(1'b0, 1'b1, (nvalid == 6) ? 1'b0 : 1'b1);
        nvalid++;
      end else begin
        step(1'b0, 1'b0, 1'b0);
      end
      if (nvalid < 8) begin
        check_val("gap_busy", int'(bus.busy_amisha), 1);
        check_val("gap_done", int'(bus.done_amisha), 0);
      end else begin
        check_val("gap_done_end", int'(bus.done_amisha), 1);
      end
    end
    check_result("gap", 0, 1, 6);

    // bit_valid in IDLE has no effect.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    check_val("idlevalid_busy", int'(bus.busy_amisha), 0);
    check_result("idlevalid", 0, 1, 6);

    // start+valid together: start taken, that bit not consumed; start in RUN ignored.
    step(1'b1, 1'b1, 1'b0);
    check_val("sv_busy", int'(bus.busy_amisha), 1);
    check_val("sv_errcnt", int'(bus.err_count_amisha), 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1);
    check_val("sv_done_after7", int'(bus.done_amisha), 0);
    check_val("sv_busy_after7", int'(bus.busy_amisha), 1);
    step(1'b1, 1'b1, 1'b1);
    check_val("sv_done", int'(bus.done_amisha), 1);
    check_result("sv", 1, 0, 0);
    // start during DONE must not open a frame.
    step(1'b1, 1'b0, 1'b0);
    check_val("donestart_busy", int'(bus.busy_amisha), 0);
    check_val("donestart_done", int'(bus.done_amisha), 0);
    step(1'b0, 1'b0, 1'b0);
    check_val("donestart_busy2", int'(bus.busy_amisha), 0);

    // Asynchronous reset after 4 unequal bits.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    check_val("pre_rst_errcnt", int'(bus.err_count_amisha), 4);
    #2;
    reset_amisha = 1'b1;
    #1;
    check_val("arst_busy", int'(bus.busy_amisha), 0);
    check_val("arst_done", int'(bus.done_amisha), 0);
    check_result("arst", 0, 0, 0);
    @(posedge clk_amisha);
    #1;
    reset_amisha = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1);
      check_val("postrst_done", int'(bus.done_amisha), 0);
      check_val("postrst_busy", int'(bus.busy_amisha), 0);
    end
    run_frame("postrst", 8'b0111_1111, 0, 1, 7);

    $display("Result: errors=%0d of %0d checks", errors_q, checks_q);
    $finish;
  end
endmodule
